// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle control FSM. Steps the datapath one instruction at a time:
//   FETCH -> DECODE -> execute / memory / write-back, and drives every
//   datapath strobe and mux select. Memory accesses wait on MemReady.
// Ports
//   CLK, RST_n                 clock (rising edge), async active-low reset
//   OPcode, Func               instruction fields from the decoder
//   Zero                       ALU zero flag (branch condition)
//   MemReady                   memory finishes the current access this cycle
//   PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
//   ALUSrcA, ALUSrcB, ALUOp, PCSrc   datapath controls
//   State                      current state (debug)
//   Retired                    retired-instruction counter (wraps)
//   Fault                      sticky illegal-instruction flag
module multicycle_ctrl (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [5:0]  OPcode,
  input  logic [5:0]  Func,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSrc,
  output logic [3:0]  State,
  output logic [15:0] Retired,
  output logic        Fault
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_MEMADR  = 4'd4,
    S_MEMRD   = 4'd5,
    S_MEMWB   = 4'd6,
    S_MEMWR   = 4'd7,
    S_RWB     = 4'd8,
    S_IWB     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [5:0]  func_q, func_d;
  logic [15:0] retired_q, retired_d;
  logic        fault_q, fault_d;
  logic        retire;

  // Supported R-type functions: add, sub, and, or, slt.
  function automatic logic func_ok(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      func_q    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      func_q    <= func_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    func_d   = func_q;
    fault_d  = fault_q;
    retire   = 1'b0;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR and PC+4 are loaded only on the cycle the read completes.
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB = 2'b11;
        op_d    = OPcode;
        func_d  = Func;
        if (OPcode == OP_RTYPE && func_ok(Func))     state_d = S_EXEC_R;
        else if (OPcode == OP_LW || OPcode == OP_SW) state_d = S_MEMADR;
        else if (OPcode == OP_BEQ || OPcode == OP_BNE) state_d = S_BRANCH;
        else if (OPcode == OP_ADDI)                  state_d = S_EXEC_I;
        else if (OPcode == OP_J)                     state_d = S_JUMP;
        else                                         state_d = S_ILLEGAL;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        // func_q was already vetted in DECODE; the recheck is defensive.
        state_d = func_ok(func_q) ? S_RWB : S_ILLEGAL;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        PCWrite = ((op_q == OP_BEQ) && Zero) || ((op_q == OP_BNE) && !Zero);
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: begin
        fault_d = 1'b1;
      end
      default: state_d = S_ILLEGAL;
    endcase

    // Reset kills every strobe combinationally so a pending memory access
    // drops with RST_n, without waiting for a clock edge.
    if (!RST_n) begin
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSrc    = 2'b00;
    end
  end

  assign retired_d = retire ? retired_q + 16'd1 : retired_q;
  assign State     = state_q;
  assign Retired   = retired_q;
  assign Fault     = fault_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM that sequences the processor datapath one instruction at a time: fetch through the shared memory port, decode using the OPcode/Func fields from the instruction decoder, then execute, memory access and write-back. Drives all datapath strobes and muxes and handles a ready/wait handshake on memory. Sits beside the instruction decoder and replaces the single-cycle combinational control when the processor runs in multi-cycle mode.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- OPcode  in  6  opcode from the instruction decoder; valid from DECODE onward.
- Func  in  6  R-type function field from the instruction decoder.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  load PC.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead / MemWrite  out  1 each  memory strobes; held until MemReady.
- IRWrite  out  1  load instruction register.
- RegWrite  out  1  register file write.
- RegDst  out  1  destination: 0 = RT, 1 = RD.
- MemtoReg  out  1  write-back data: 0 = ALUOut, 1 = memory data.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended Imm, 11 = sign-extended Imm << 2.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = decode Func.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], Jumpt, 2'b00}.
- State  out  4  current state encoding (debug).
- Retired  out  16  retired-instruction counter.
- Fault  out  1  sticky illegal-instruction flag.

## Operation
- States and encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEMADR 4, MEMRD 5, MEMWB 6, MEMWR 7, RWB 8, IWB 9, BRANCH 10, JUMP 11, ILLEGAL 12.
- Any output not listed for a state is 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=1 and PCWrite=1 only in the cycle MemReady=1, which moves to DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Latch OPcode and Func internally. Dispatch:
  - 000000 with Func in {100000, 100010, 100100, 100101, 101010} -> EXEC_R.
  - 100011 or 101011 -> MEMADR.
  - 000100 or 000101 -> BRANCH.
  - 001000 -> EXEC_I.
  - 000010 -> JUMP.
  - anything else -> ILLEGAL.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD for latched 100011, MEMWR for latched 101011.
- MEMRD: IorD=1, MemRead=1; wait until MemReady=1 -> MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1; wait until MemReady=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01. PCWrite = (latched beq & Zero) | (latched bne & ~Zero) -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- ILLEGAL: Fault set to 1; all strobes 0; remain in ILLEGAL until reset.
- Retired increments by 1 (mod 2^16, wraps FFFF -> 0000) on the exit edge of:
  - RWB, IWB, MEMWB, BRANCH, JUMP;
  - MEMWR when MemReady=1.
- Retired never increments on ILLEGAL.

## Timing
- Control outputs are Moore, decoded from State. Exceptions: FETCH IRWrite/PCWrite qualified by MemReady, and BRANCH PCWrite qualified by Zero.
- While RST_n=0: State=0 (FETCH), Retired=0, Fault=0, latched opcode/func=0, all control outputs forced to 0. Reset applies immediately, including mid-instruction; a pending MemRead/MemWrite drops in the same cycle.
- The first FETCH strobes appear in the first cycle after RST_n rises.
- Latency with MemReady tied high: R-type 4 cycles, addi 4, lw 5, sw 4, beq/bne 3, j 3. Each cycle MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- MemReady is ignored in all states except FETCH, MEMRD and MEMWR.

## Test plan
- Reset: hold RST_n=0 with MemReady=1 -> State=0, Retired=0, Fault=0, all strobes 0; release -> MemRead=1, IorD=0 in the next cycle.
- add: OPcode=000000, Func=100000, MemReady=1 -> states 0,1,2,8,0; RegWrite=1 with RegDst=1 exactly in state 8; Retired=1.
- lw with 2-cycle memory waits in both FETCH and MEMRD -> states 0,0,0,1,4,5,5,5,6,0 (10 cycles); MemRead held high throughout the waits; IRWrite pulses once.
- beq with Zero=1 -> PCWrite=1 and PCSrc=01 in BRANCH. bne with Zero=1 -> PCWrite=0 in BRANCH. Each adds 1 to Retired.
- Illegal: OPcode=111111 -> ILLEGAL (State=12), Fault=1 sticky for 20 cycles with all strobes 0; RST_n pulse clears it. Also R-type with Func=000111 -> ILLEGAL.
- Reset mid-MEMRD with MemReady=0 -> MemRead falls with RST_n without waiting for a clock; after release State=0 and Retired=0. Separately, preload Retired=FFFF via 65535 j instructions, then one more j -> Retired=0000.
